// File: rtl/encoder_stream8_pkg.sv
// encoder_stream8_pkg
// Shared definitions for the streaming multi-hot encoder: vector and code
// widths plus the two-state FSM type used by encoder_stream8.
package encoder_stream8_pkg;

    localparam int VEC_W  = 8;
    localparam int CODE_W = 3;

    typedef enum logic {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

endpackage

// File: rtl/encoder_stream8_prio.sv
// prio_enc8
// Purely combinational priority encoder over an 8-bit vector.
// Ports:
//   i_vec  : vector to scan
//   o_idx  : index of the selected set bit (0 when nothing is set)
//   o_any  : 1 when at least one bit of i_vec is set
// MSB_FIRST selects whether the highest (1) or lowest (0) set bit wins.
module prio_enc8
    import encoder_stream8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic [VEC_W-1:0]  i_vec,
    output logic [CODE_W-1:0] o_idx,
    output logic              o_any
);

    // The scan direction is chosen so that the winning bit is the one
    // visited last; later assignments override earlier ones.
    always_comb begin
        o_idx = '0;
        o_any = |i_vec;
        if (MSB_FIRST) begin
            for (int i = 0; i < VEC_W; i++) begin
                if (i_vec[i]) begin
                    o_idx = CODE_W'(i);
                end
            end
        end else begin
            for (int i = VEC_W - 1; i >= 0; i--) begin
                if (i_vec[i]) begin
                    o_idx = CODE_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/encoder_stream8.sv
// encoder_stream8
// Accepts one multi-hot vector at a time and streams out the index of every
// set bit, one beat per set bit, in LSB-first or MSB-first order. An all-zero
// vector yields a single "none" beat.
// Ports:
//   clk, rst               : clock and asynchronous active-high reset
//   in_valid/in_ready/in_vec : input vector handshake
//   out_valid/out_ready    : output beat handshake
//   out_code               : index of the selected set bit
//   out_seq                : beat number within the current burst
//   out_last               : final beat of the burst
//   out_none               : captured vector was all zeros
module encoder_stream8
    import encoder_stream8_pkg::*;
#(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [VEC_W-1:0]  in_vec,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [CODE_W-1:0] out_seq,
    output logic              out_last,
    output logic              out_none
);

    state_t              r_state;
    state_t              w_nextState;
    logic [VEC_W-1:0]    r_pending;
    logic [CODE_W-1:0]   r_seq;
    logic [CODE_W-1:0]   w_idx;
    logic                w_anySet;
    logic                w_oneLeft;
    logic                w_inFire;
    logic                w_outFire;
    logic                w_emitting;

    prio_enc8 #(
        .MSB_FIRST(MSB_FIRST)
    ) u_prio (
        .i_vec (r_pending),
        .o_idx (w_idx),
        .o_any (w_anySet)
    );

    // Clearing the lowest set bit leaves zero only when exactly one was set.
    assign w_oneLeft  = w_anySet && ((r_pending & (r_pending - 8'd1)) == 8'd0);
    assign w_emitting = (r_state == EMIT);
    assign w_inFire   = in_valid && in_ready;
    assign w_outFire  = out_valid && out_ready;

    // In EMIT an empty pending register can only mean a zero vector was
    // captured, because the last real bit always returns the FSM to IDLE.
    assign in_ready  = !w_emitting;
    assign out_valid = w_emitting;
    assign out_none  = w_emitting && !w_anySet;
    assign out_code  = (w_emitting && w_anySet) ? w_idx : '0;
    assign out_seq   = w_emitting ? r_seq : '0;
    assign out_last  = w_emitting && (w_oneLeft || !w_anySet);

    // State register for the IDLE/EMIT controller.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state logic: capture moves to EMIT, the accepted last beat
    // returns to IDLE.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_inFire) w_nextState = EMIT;
            EMIT:    if (w_outFire && out_last) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    // Pending bits and beat counter. The counter is not advanced on the
    // last beat so a full 0xFF burst never wraps from 7 back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pending <= '0;
            r_seq     <= '0;
        end else if (w_inFire) begin
            r_pending <= in_vec;
            r_seq     <= '0;
        end else if (w_outFire) begin
            r_pending <= r_pending & ~(8'd1 << w_idx);
            if (!out_last) begin
                r_seq <= r_seq + 3'd1;
            end
        end
    end

endmodule

// File: tb/tb_encoder_stream8.sv
// tb_encoder_stream8
// Drives two encoder instances (LSB-first and MSB-first) with one shared
// stimulus stream. Both consume the same number of beats per vector, so
// their handshakes stay in lockstep. A reference model built from the
// list of set-bit indices predicts every output on every cycle.
module tb_encoder_stream8;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_vec;
    logic       out_ready;

    logic       inReadyL, outValidL, outLastL, outNoneL;
    logic [2:0] outCodeL, outSeqL;
    logic       inReadyM, outValidM, outLastM, outNoneM;
    logic [2:0] outCodeM, outSeqM;

    int nCompared   = 0;
    int nMismatched = 0;

    // Reference model: the expected beat list for the burst in flight.
    int  qL[$];
    int  qM[$];
    bit  mActive = 1'b0;
    bit  mNone   = 1'b0;
    int  mPos    = 0;

    // Log of accepted beats, used by the directed literal checks.
    int  obsL[$];
    int  obsM[$];
    int  obsSeq[$];
    int  obsLast[$];
    int  obsNone[$];

    encoder_stream8 #(.MSB_FIRST(1'b0)) dutL (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (inReadyL),
        .in_vec    (in_vec),
        .out_valid (outValidL),
        .out_ready (out_ready),
        .out_code  (outCodeL),
        .out_seq   (outSeqL),
        .out_last  (outLastL),
        .out_none  (outNoneL)
    );

    encoder_stream8 #(.MSB_FIRST(1'b1)) dutM (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (inReadyM),
        .in_vec    (in_vec),
        .out_valid (outValidM),
        .out_ready (out_ready),
        .out_code  (outCodeM),
        .out_seq   (outSeqM),
        .out_last  (outLastM),
        .out_none  (outNoneM)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        nCompared++;
        if (actual != expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %0d, required %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic checkList(input string name, input int got[$], input int exp[$]);
        checkOutput({name, ".len"}, got.size(), exp.size());
        for (int i = 0; i < exp.size() && i < got.size(); i++) begin
            checkOutput($sformatf("%s[%0d]", name, i), got[i], exp[i]);
        end
    endtask

    // Per-cycle compare at the falling edge, then advance the model using
    // the inputs that will be seen at the next rising edge.
    always @(negedge clk) begin
        int  expCode;
        int  expCodeM;
        int  expSeq;
        bit  expLast;
        if (rst) begin
            qL.delete();
            qM.delete();
            mActive = 1'b0;
            mNone   = 1'b0;
            mPos    = 0;
        end
        expCode  = mActive ? qL[mPos] : 0;
        expCodeM = mActive ? qM[mPos] : 0;
        expSeq   = mActive ? mPos : 0;
        expLast  = mActive && (mPos == qL.size() - 1);

        checkOutput("L.in_ready",  int'(inReadyL),  int'(!mActive));
        checkOutput("L.out_valid", int'(outValidL), int'(mActive));
        checkOutput("L.out_code",  int'(outCodeL),  expCode);
        checkOutput("L.out_seq",   int'(outSeqL),   expSeq);
        checkOutput("L.out_last",  int'(outLastL),  int'(expLast));
        checkOutput("L.out_none",  int'(outNoneL),  int'(mActive && mNone));
        checkOutput("M.in_ready",  int'(inReadyM),  int'(!mActive));
        checkOutput("M.out_valid", int'(outValidM), int'(mActive));
        checkOutput("M.out_code",  int'(outCodeM),  expCodeM);
        checkOutput("M.out_seq",   int'(outSeqM),   expSeq);
        checkOutput("M.out_last",  int'(outLastM),  int'(expLast));
        checkOutput("M.out_none",  int'(outNoneM),  int'(mActive && mNone));

        if (!rst && outValidL && out_ready) begin
            obsL.push_back(int'(outCodeL));
            obsM.push_back(int'(outCodeM));
            obsSeq.push_back(int'(outSeqL));
            obsLast.push_back(int'(outLastL));
            obsNone.push_back(int'(outNoneL));
        end

        if (!rst) begin
            if (mActive && out_ready) begin
                mPos++;
                if (mPos == qL.size()) begin
                    mActive = 1'b0;
                    qL.delete();
                    qM.delete();
                    mPos = 0;
                end
            end else if (!mActive && in_valid) begin
                for (int i = 0; i < 8; i++) begin
                    if (in_vec[i]) begin
                        qL.push_back(i);
                        qM.push_front(i);
                    end
                end
                mNone = (in_vec == 8'h00);
                if (mNone) begin
                    qL.push_back(0);
                    qM.push_back(0);
                end
                mActive = 1'b1;
                mPos    = 0;
            end
        end
    end

    task automatic clearLog();
        obsL.delete();
        obsM.delete();
        obsSeq.delete();
        obsLast.delete();
        obsNone.delete();
    endtask

    task automatic waitIdle(input string name);
        int n = 0;
        while (!inReadyL && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!inReadyL) checkOutput({name, ".idle_timeout"}, 0, 1);
    endtask

    // Offers one vector for exactly one accepted cycle; returns #1 after
    // the capturing edge with in_vec scrambled to prove it is ignored.
    task automatic applyStimulus(input logic [7:0] v);
        waitIdle("applyStimulus");
        in_valid = 1'b1;
        in_vec   = v;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_vec   = 8'($urandom);
    endtask

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_vec    = 8'h00;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single bit: beat appears one cycle after capture, idle right after.
        out_ready = 1'b1;
        clearLog();
        applyStimulus(8'h01);
        checkOutput("single.valid", int'(outValidL), 1);
        checkOutput("single.code",  int'(outCodeL), 0);
        @(posedge clk);
        #1;
        checkOutput("single.in_ready_next", int'(inReadyL), 1);
        checkList("single.last", obsLast, '{1});

        // Multi-bit in both scan orders.
        clearLog();
        applyStimulus(8'hA4);
        waitIdle("multi");
        checkList("multi.codesL", obsL, '{2, 5, 7});
        checkList("multi.codesM", obsM, '{7, 5, 2});
        checkList("multi.seq",    obsSeq, '{0, 1, 2});
        checkList("multi.last",   obsLast, '{0, 0, 1});

        // Backpressure holds the first beat stable.
        clearLog();
        out_ready = 1'b0;
        applyStimulus(8'h81);
        for (int c = 0; c < 3; c++) begin
            checkOutput("bp.code",  int'(outCodeL), 0);
            checkOutput("bp.seq",   int'(outSeqL), 0);
            checkOutput("bp.valid", int'(outValidL), 1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        waitIdle("bp");
        checkList("bp.codes", obsL, '{0, 7});

        // Zero vector: one "none" beat.
        clearLog();
        applyStimulus(8'h00);
        checkOutput("zero.none", int'(outNoneL), 1);
        waitIdle("zero");
        checkList("zero.code", obsL, '{0});
        checkList("zero.none_log", obsNone, '{1});
        checkList("zero.last", obsLast, '{1});

        // Full vector: eight beats, seq 0..7, no wrap.
        clearLog();
        applyStimulus(8'hFF);
        waitIdle("full");
        checkList("full.seq",  obsSeq, '{0, 1, 2, 3, 4, 5, 6, 7});
        checkList("full.last", obsLast, '{0, 0, 0, 0, 0, 0, 0, 1});
        checkList("full.codesM", obsM, '{7, 6, 5, 4, 3, 2, 1, 0});

        // Reset mid-burst discards the remainder immediately.
        applyStimulus(8'hA4);
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        checkOutput("rst.valid",    int'(outValidL), 0);
        checkOutput("rst.in_ready", int'(inReadyL), 1);
        checkOutput("rst.code",     int'(outCodeL), 0);
        checkOutput("rst.seq",      int'(outSeqL), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        clearLog();
        repeat (4) @(posedge clk);
        #1;
        checkOutput("rst.no_beats", obsL.size(), 0);

        // Randomized traffic, with rare reset pulses.
        for (int c = 0; c < 1500; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_vec    = ($urandom_range(0, 9) == 0) ? 8'h00 : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rst       = ($urandom_range(0, 149) == 0);
            @(posedge clk);
            #1;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/encoder_stream8.md
ENCODER_STREAM8 -- requirements
Module: encoder_stream8

Interface
REQ-001 Parameter: MSB_FIRST, default 0, scan order (0 = lowest set bit first, 1 = highest set bit first).
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 in_valid  input  1  producer offers in_vec.
REQ-006 in_ready  output  1  block can accept a vector.
REQ-007 in_vec  input  8  multi-hot vector to encode.
REQ-008 out_valid  output  1  out_code/out_seq/out_last/out_none are valid.
REQ-009 out_ready  input  1  consumer accepts the current beat.
REQ-010 out_code  output  3  binary index of the selected set bit.
REQ-011 out_seq  output  3  zero-based beat number within the current burst.
REQ-012 out_last  output  1  current beat is the final beat of the burst.
REQ-013 out_none  output  1  captured vector was all zeros; beat carries no index.

Function
REQ-014 The block SHALL implement a two-state FSM: IDLE and EMIT.
REQ-015 In IDLE, in_ready SHALL be 1 and out_valid 0; in EMIT, in_ready SHALL be 0 and out_valid 1.
REQ-016 Input handshake (in_valid & in_ready) SHALL register in_vec into an 8-bit pending register, clear out_seq to 0, and enter EMIT on the next edge.
REQ-017 First output beat SHALL appear exactly one cycle after the input handshake.
REQ-018 out_code SHALL be the index of the lowest set pending bit (MSB_FIRST=0) or the highest (MSB_FIRST=1), computed combinationally from the pending register.
REQ-019 out_last SHALL be 1 when the pending register has exactly one bit set, or when out_none=1.
REQ-020 Output handshake (out_valid & out_ready) SHALL clear the selected pending bit and increment out_seq by 1.
REQ-021 Output handshake with out_last=1 SHALL return the FSM to IDLE; in_ready is 1 in the following cycle.
REQ-022 A captured zero vector SHALL produce exactly one beat: out_none=1, out_code=0, out_seq=0, out_last=1.
REQ-023 While out_valid=1 and out_ready=0, out_code, out_seq, out_last and out_none SHALL hold stable.
REQ-024 in_vec SHALL be ignored outside an input handshake; changes during EMIT SHALL have no effect.
REQ-025 A burst of N set bits (1..8) SHALL produce exactly N beats with out_seq 0..N-1; 0xFF SHALL yield out_seq 7 on the last beat without wrap.
REQ-026 In IDLE, out_code, out_seq, out_last and out_none SHALL be 0.

Reset
REQ-027 Asserting rst SHALL immediately force IDLE, pending=0, out_valid=0, in_ready=1, and all other outputs to 0.
REQ-028 rst asserted mid-burst SHALL discard the remaining pending bits; no further beats of that burst SHALL be emitted.
REQ-029 The first input handshake SHALL be possible on the first rising edge after rst deasserts.

Structure
REQ-030 A shared package SHALL hold the FSM state type (IDLE, EMIT) and the constants VEC_W=8 and CODE_W=3.
REQ-031 The priority selection SHALL be a separate combinational sub-module prio_enc8 (8-bit vector in, 3-bit index plus any-set flag out, MSB_FIRST parameter).
REQ-032 All state SHALL reside in encoder_stream8; prio_enc8 SHALL contain no storage.

Verification
REQ-033 Reset: rst=1 mid-burst of 0xA4 -> outputs go to 0 and in_ready=1 immediately; no further beats appear after release.
REQ-034 Single bit: in_vec=0x01, out_ready=1 -> one beat next cycle with code=0, seq=0, last=1; in_ready=1 the following cycle.
REQ-035 Multi-bit: in_vec=0xA4, MSB_FIRST=0, out_ready=1 -> codes 2,5,7 on consecutive cycles with seq 0,1,2; last=1 only on code 7.
REQ-036 Backpressure: in_vec=0x81, out_ready=0 for 3 cycles -> code=0, seq=0 held stable; then codes 0,7 emitted.
REQ-037 Zero vector: in_vec=0x00 -> one beat with none=1, code=0, last=1.
REQ-038 Order and full vector: MSB_FIRST=1, in_vec=0xA4 -> codes 7,5,2; in_vec=0xFF -> 8 beats, seq 0..7, last on seq 7.
